// File: rtl/multi_dataflow_out_buffer_if.sv
// Valid/ready beat stream carrying data plus a byte strobe.
// The master drives valid/data/strb and the slave drives ready.
interface multi_dataflow_out_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/multi_dataflow_out_buffer.sv
// Output buffer between a dataflow engine and the streamer sink.
// Counts a job of len beats through a small FIFO and pulses done_o once every beat has left.
module multi_dataflow_out_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [15:0]                   len_i,
  multi_dataflow_out_buffer_if.slave    in_i,
  multi_dataflow_out_buffer_if.master   out_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e state_q, state_d;

  logic [15:0]           len_q, len_d;
  logic [15:0]           in_cnt_q, in_cnt_d;
  logic [15:0]           out_cnt_q, out_cnt_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [SW-1:0]         strb_mem_q [DEPTH];

  logic flush;
  logic fifo_full;
  logic fifo_empty;
  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;
  logic last_in;
  logic last_out;

  assign flush      = rst_i | clear_i;
  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push     = in_i.valid && in_ready;
  assign pop      = out_valid && out_o.ready;
  assign last_in  = push && ((in_cnt_q + 16'd1) == len_q);
  assign last_out = pop && ((out_cnt_q + 16'd1) == len_q);

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && (len_i != 16'd0)) state_d = RUN;
      RUN:     if (last_in) state_d = DRAIN;
      DRAIN:   if (last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on registered state, never on out_ready.
  always_comb begin
    busy_o    = (state_q != IDLE);
    in_ready  = (state_q == RUN) && !fifo_full && (in_cnt_q < len_q);
    out_valid = (state_q != IDLE) && !fifo_empty;
  end

  always_comb begin
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;

    if ((state_q == IDLE) && start_i) begin
      len_d     = len_i;
      in_cnt_d  = 16'd0;
      out_cnt_d = 16'd0;
      done_d    = (len_i == 16'd0);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      in_cnt_d = in_cnt_q + 16'd1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (out_cnt_q != len_q) begin
        out_cnt_d = out_cnt_q + 16'd1;
      end
    end

    if ((state_q == DRAIN) && last_out) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      len_q     <= 16'd0;
      in_cnt_q  <= 16'd0;
      out_cnt_q <= 16'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
    end
  end

  // Storage is not reset; the output mux below hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      data_mem_q[wr_ptr_q[AW-1:0]] <= in_i.data;
      strb_mem_q[wr_ptr_q[AW-1:0]] <= in_i.strb;
    end
  end

  assign in_i.ready  = in_ready;
  assign out_o.valid = out_valid;
  assign out_o.data  = out_valid ? data_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_o.strb  = out_valid ? strb_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign done_o      = done_q;
  assign cnt_o       = out_cnt_q;

endmodule

// File: tb/tb_multi_dataflow_out_buffer.sv
// Directed testbench for multi_dataflow_out_buffer: short jobs with hand-derived
// expectations, a FIFO full/refusal case, flush behaviour and a long stalled stream.
module tb_multi_dataflow_out_buffer;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] cnt;

  multi_dataflow_out_buffer_if #(.DATA_WIDTH(DW)) inBus ();
  multi_dataflow_out_buffer_if #(.DATA_WIDTH(DW)) outBus ();

  multi_dataflow_out_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .start_i (start),
    .len_i   (len),
    .in_i    (inBus.slave),
    .out_o   (outBus.master),
    .busy_o  (busy),
    .done_o  (done),
    .cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;
  int jobLen = 0;
  int inIdx = 0;
  int outIdx = 0;

  function automatic logic [DW-1:0] beatData(input int i);
    logic [31:0] v;
    v = 32'(i);
    return 32'hC0DE_0000 ^ (v << 20) ^ v;
  endfunction

  function automatic logic [SW-1:0] beatStrb(input int i);
    logic [31:0] v;
    v = 32'(i);
    return v[3:0] ^ 4'h9;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] l, input logic iv,
                               input logic [DW-1:0] d, input logic [SW-1:0] st, input logic ordy);
    start        = s;
    len          = l;
    inBus.valid  = iv;
    inBus.data   = d;
    inBus.strb   = st;
    outBus.ready = ordy;
  endtask

  // Streams beats inIdx..jobLen-1 and checks every popped beat against the sequence
  // starting at outIdx, then checks the single done pulse and final counters.
  task automatic runStream(input int maxCycles, input bit randomStall);
    int cycles;
    int doneCount;
    logic rdy;
    cycles = 0;
    doneCount = 0;
    while (doneCount == 0 && cycles < maxCycles) begin
      rdy = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b0, len, (inIdx < jobLen), beatData(inIdx), beatStrb(inIdx), rdy);
      #1;
      if (outBus.valid && outBus.ready) begin
        checkOutput("stream_data", outBus.data, beatData(outIdx));
        checkOutput("stream_strb", outBus.strb, beatStrb(outIdx));
        outIdx++;
      end
      if (inBus.valid && inBus.ready) inIdx++;
      tick();
      cycles++;
      if (done) doneCount++;
    end
    applyStimulus(1'b0, len, 1'b0, '0, '0, 1'b1);
    checkOutput("stream_done_seen", doneCount, 1);
    checkOutput("stream_in_count", inIdx, jobLen);
    checkOutput("stream_out_count", outIdx, jobLen);
    checkOutput("stream_cnt", cnt, jobLen);
    checkOutput("stream_busy_end", busy, 0);
    tick();
    checkOutput("stream_done_once", done, 0);
    checkOutput("stream_cnt_hold", cnt, jobLen);
  endtask

  initial begin
    logic [DW-1:0] vals [3];
    vals[0] = 32'hA;
    vals[1] = 32'hB;
    vals[2] = 32'hC;

    applyStimulus(1'b0, 16'd0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_in_ready", inBus.ready, 0);
    checkOutput("rst_out_valid", outBus.valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_out_data", outBus.data, 0);
    checkOutput("rst_out_strb", outBus.strb, 0);

    // len=3, back-to-back A/B/C with the sink always ready.
    applyStimulus(1'b1, 16'd3, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd3, 1'b0, '0, '0, 1'b1);
    checkOutput("j3_busy", busy, 1);
    checkOutput("j3_in_ready", inBus.ready, 1);
    checkOutput("j3_out_valid_pre", outBus.valid, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'd3, 1'b1, vals[i], 4'hF, 1'b1);
      tick();
      checkOutput("j3_out_valid", outBus.valid, 1);
      checkOutput("j3_out_data", outBus.data, vals[i]);
      checkOutput("j3_out_strb", outBus.strb, 4'hF);
    end
    applyStimulus(1'b0, 16'd3, 1'b0, '0, '0, 1'b1);
    checkOutput("j3_drain_in_ready", inBus.ready, 0);
    checkOutput("j3_drain_busy", busy, 1);
    tick();
    checkOutput("j3_done", done, 1);
    checkOutput("j3_busy_end", busy, 0);
    checkOutput("j3_cnt", cnt, 3);
    checkOutput("j3_out_valid_end", outBus.valid, 0);
    tick();
    checkOutput("j3_done_drop", done, 0);
    checkOutput("j3_cnt_hold", cnt, 3);

    // len=0 completes immediately without ever accepting a beat.
    applyStimulus(1'b1, 16'd0, 1'b1, 32'h1234, 4'h1, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd0, 1'b1, 32'h1234, 4'h1, 1'b1);
    checkOutput("l0_done", done, 1);
    checkOutput("l0_busy", busy, 0);
    checkOutput("l0_in_ready", inBus.ready, 0);
    tick();
    checkOutput("l0_done_drop", done, 0);
    checkOutput("l0_busy_after", busy, 0);

    // len=8 with the sink stalled: four accepts fill the FIFO, then a
    // full-and-popping cycle refuses the push before the stream resumes.
    jobLen = 8;
    applyStimulus(1'b1, 16'd8, 1'b0, '0, '0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 16'd8, 1'b1, beatData(k), beatStrb(k), 1'b0);
      #1;
      checkOutput("j8_fill_ready", inBus.ready, 1);
      tick();
    end
    inIdx = 4;
    outIdx = 0;
    applyStimulus(1'b0, 16'd8, 1'b1, beatData(4), beatStrb(4), 1'b0);
    checkOutput("j8_full_ready", inBus.ready, 0);
    checkOutput("j8_full_valid", outBus.valid, 1);
    checkOutput("j8_head_data", outBus.data, beatData(0));
    tick();
    checkOutput("j8_stall_ready", inBus.ready, 0);
    checkOutput("j8_stall_data", outBus.data, beatData(0));
    applyStimulus(1'b0, 16'd8, 1'b1, beatData(4), beatStrb(4), 1'b1);
    checkOutput("j8_refuse_ready", inBus.ready, 0);
    tick();
    outIdx = 1;
    checkOutput("j8_pop_data", outBus.data, beatData(1));
    checkOutput("j8_occ3_ready", inBus.ready, 1);
    runStream(200, 1'b0);

    // clear mid-job after two accepted beats (one already delivered).
    applyStimulus(1'b1, 16'd5, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 16'd5, 1'b1, beatData(0), beatStrb(0), 1'b1);
    tick();
    applyStimulus(1'b0, 16'd5, 1'b1, beatData(1), beatStrb(1), 1'b1);
    tick();
    checkOutput("clr_cnt_before", cnt, 1);
    checkOutput("clr_valid_before", outBus.valid, 1);
    clear = 1'b1;
    applyStimulus(1'b0, 16'd5, 1'b0, '0, '0, 1'b1);
    tick();
    clear = 1'b0;
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_out_valid", outBus.valid, 0);
    checkOutput("clr_cnt", cnt, 0);
    checkOutput("clr_done", done, 0);
    checkOutput("clr_out_data", outBus.data, 0);
    checkOutput("clr_in_ready", inBus.ready, 0);
    tick();
    checkOutput("clr_done_later", done, 0);

    // rst_i mid-job together with start_i: reset wins, no done, job not restarted.
    applyStimulus(1'b1, 16'd4, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 16'd4, 1'b1, beatData(0), beatStrb(0), 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 16'd2, 1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'd2, 1'b0, '0, '0, 1'b0);
    checkOutput("rstprio_busy", busy, 0);
    checkOutput("rstprio_done", done, 0);
    checkOutput("rstprio_valid", outBus.valid, 0);
    tick();
    checkOutput("rstprio_busy_later", busy, 0);
    checkOutput("rstprio_done_later", done, 0);

    // A fresh len=1 job after the flushes completes normally.
    applyStimulus(1'b1, 16'd1, 1'b0, '0, '0, 1'b1);
    tick();
    jobLen = 1;
    inIdx = 0;
    outIdx = 0;
    runStream(50, 1'b0);

    // Long job with a randomly stalling sink to wrap the pointers many times.
    applyStimulus(1'b1, 16'd1000, 1'b0, '0, '0, 1'b0);
    tick();
    jobLen = 1000;
    inIdx = 0;
    outIdx = 0;
    runStream(20000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
